word2byte_dump: RTL and testbench

Memory readback serializer: streams a block of 32-bit words from the instruction/data RAM out as a byte stream, low byte first. It is the byte-order inverse of the programming path, so a dump of a freshly programmed image reproduces the original download byte for byte. It sits between the RAM port mux and the byte-level transmit front end (UART TX).

While a dump is active, it owns the RAM port. When idle, the CPU's memory signals pass through unchanged.

---
 rtl/word2byte_dump.sv | 134 +++++++++++++
 tb/tb_word2byte_dump.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word2byte_dump.sv
// word2byte_dump
// ---------------------------------------------------------------------------
// Memory readback serializer. Reads a block of 32-bit words from RAM starting
// at word address 0 and emits them as a byte stream, low byte first, so that
// a dump of a freshly programmed image reproduces the download byte for byte.
// While a dump is in progress the block owns the RAM port; otherwise the CPU
// memory signals pass straight through.
//
// Ports
//   clkMem     memory clock, all state changes on its rising edge
//   rstn       synchronous active-low reset
//   dumpEn     level: high requests/holds a dump, low aborts or acknowledges
//   wordCnt    number of words to dump (sampled at start, clamped to 2^AW)
//   addrIn     CPU word address
//   weIn       CPU byte write enables
//   enIn       CPU RAM enable
//   memData    RAM read data, valid the cycle after address+enable
//   addrOut    RAM address (dump pointer while busy, else addrIn)
//   weOut      RAM write enables (zero while busy, else weIn)
//   enOut      RAM enable (read strobe while busy, else enIn)
//   byteData   serialized byte
//   byteValid  byteData valid
//   byteReady  sink accepts the byte when high together with byteValid
//   busy       high whenever a dump is in progress or finished-but-held
//   dumpDone   high once all words have been sent, until dumpEn drops
// ---------------------------------------------------------------------------
module word2byte_dump #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clkMem,
   input  logic                  rstn,
   input  logic                  dumpEn,
   input  logic [ADDR_WIDTH:0]   wordCnt,
   input  logic [ADDR_WIDTH-1:0] addrIn,
   input  logic [3:0]            weIn,
   input  logic                  enIn,
   input  logic [31:0]           memData,
   output logic [ADDR_WIDTH-1:0] addrOut,
   output logic [3:0]            weOut,
   output logic                  enOut,
   output logic [7:0]            byteData,
   output logic                  byteValid,
   input  logic                  byteReady,
   output logic                  busy,
   output logic                  dumpDone
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      TX   = 3'd3,
      DONE = 3'd4
   } state_t;

   // Largest legal word count: the whole address space.
   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [ADDR_WIDTH:0]   remaining;
   logic [31:0]           shreg;
   logic [1:0]            byte_cnt;
   logic                  byte_valid;
   logic [ADDR_WIDTH:0]   cnt_clamped;
   logic                  handshake;
   logic                  abort;

   assign cnt_clamped = (wordCnt > MAX_WORDS) ? MAX_WORDS : wordCnt;
   assign handshake   = byte_valid & byteReady;
   // Dropping dumpEn anywhere outside IDLE returns everything to reset values;
   // this is also the normal exit from DONE.
   assign abort       = (state != IDLE) && !dumpEn;

   always_ff @(posedge clkMem) begin
      if (!rstn || abort) begin
         state      <= IDLE;
         ptr        <= '0;
         remaining  <= '0;
         shreg      <= '0;
         byte_cnt   <= '0;
         byte_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (dumpEn) begin
                  ptr       <= '0;
                  remaining <= cnt_clamped;
                  state     <= (cnt_clamped == '0) ? DONE : RD;
               end
            end
            // Address and read strobe are presented combinationally from ptr
            // for this single cycle; data arrives during CAP.
            RD: state <= CAP;
            CAP: begin
               shreg      <= memData;
               byte_cnt   <= '0;
               byte_valid <= 1'b1;
               state      <= TX;
            end
            TX: begin
               // Without a handshake nothing here changes, so byteData and
               // byteValid hold steady while the sink stalls.
               if (handshake) begin
                  shreg    <= shreg >> 8;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     byte_valid <= 1'b0;
                     // On the final word of a full-size dump ptr rolls to 0,
                     // but it is never used again before DONE.
                     ptr        <= ptr + 1'b1;
                     remaining  <= remaining - 1'b1;
                     state      <= (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? DONE : RD;
                  end
               end
            end
            // Held here while dumpEn stays high; release is via abort.
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign dumpDone  = (state == DONE);
   assign byteValid = byte_valid;
   assign byteData  = shreg[7:0];

   // RAM port mux: the dump never writes, and only strobes enable in RD.
   assign addrOut = busy ? ptr : addrIn;
   assign weOut   = busy ? 4'h0 : weIn;
   assign enOut   = busy ? (state == RD) : enIn;

endmodule

// File: tb/tb_word2byte_dump.sv
module tb_word2byte_dump;
   localparam int AW = 10;

   logic          clkMem = 1'b0;
   logic          rstn, dumpEn, enIn, byteReady;
   logic [AW:0]   wordCnt;
   logic [AW-1:0] addrIn, addrOut;
   logic [3:0]    weIn, weOut;
   logic [31:0]   memData = 32'h0;
   logic          enOut, byteValid, busy, dumpDone;
   logic [7:0]    byteData;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram [0:1023];

   always #5 clkMem = ~clkMem;

   // Synchronous-read RAM model: data valid the cycle after the strobe.
   always @(posedge clkMem) if (enOut) memData <= ram[addrOut];

   word2byte_dump #(.ADDR_WIDTH(AW)) dut (
      .clkMem(clkMem), .rstn(rstn), .dumpEn(dumpEn), .wordCnt(wordCnt),
      .addrIn(addrIn), .weIn(weIn), .enIn(enIn), .memData(memData),
      .addrOut(addrOut), .weOut(weOut), .enOut(enOut),
      .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
      .busy(busy), .dumpDone(dumpDone)
   );

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic test_reset();
      rstn = 1'b0; dumpEn = 1'b0; wordCnt = '0; byteReady = 1'b0;
      addrIn = 10'h055; weIn = 4'h3; enIn = 1'b0;
      repeat (2) @(negedge clkMem);
      checks++;
      if ({busy, dumpDone, byteValid, byteData} !== 11'h0) begin
         errors++;
         $display("FAIL reset_outputs: got busy/done/valid/data=%b/%b/%b/%h, exp 0/0/0/00",
                  busy, dumpDone, byteValid, byteData);
      end
      checks++;
      if ({addrOut, weOut, enOut} !== {10'h055, 4'h3, 1'b0}) begin
         errors++;
         $display("FAIL reset_port: got %h/%h/%b, exp 055/3/0", addrOut, weOut, enOut);
      end
      rstn = 1'b1;
      @(negedge clkMem);
   endtask

   task automatic test_passthrough();
      dumpEn = 1'b0; addrIn = 10'h3FF; weIn = 4'hA; enIn = 1'b1;
      @(negedge clkMem);
      checks++;
      if ({addrOut, weOut, enOut} !== {10'h3FF, 4'hA, 1'b1}) begin
         errors++;
         $display("FAIL passthrough: got %h/%h/%b, exp 3ff/a/1", addrOut, weOut, enOut);
      end
   endtask

   task automatic test_four_words();
      int hs = 0, cyc = 0, rise = -1, we_bad = 0;
      bit done = 0;
      wordCnt = 11'd4; byteReady = 1'b1; weIn = 4'hF; enIn = 1'b0; addrIn = 10'h3FF;
      dumpEn = 1'b1;
      while (!done && cyc < 100) begin
         @(negedge clkMem); cyc++;
         if (cyc == 1) begin
            checks++;
            if ({busy, addrOut, enOut} !== {1'b1, 10'h000, 1'b1}) begin
               errors++;
               $display("FAIL four_rd: got busy/addr/en=%b/%h/%b, exp 1/000/1", busy, addrOut, enOut);
            end
         end
         if (busy && weOut !== 4'h0) we_bad++;
         if (byteValid && rise < 0) rise = cyc;
         if (byteValid) begin
            checks++;
            if (byteData !== 8'(hs) || cyc != 3 + 6 * (hs / 4) + (hs % 4)) begin
               errors++;
               $display("FAIL four_byte%0d: got %h at cycle %0d, exp %h at cycle %0d",
                        hs, byteData, cyc, 8'(hs), 3 + 6 * (hs / 4) + (hs % 4));
            end
            hs++;
         end
         if (dumpDone) begin
            done = 1;
            checks++;
            if (hs != 16 || cyc != 25 || byteValid !== 1'b0) begin
               errors++;
               $display("FAIL four_done: got %0d bytes, cycle %0d, valid %b; exp 16, 25, 0",
                        hs, cyc, byteValid);
            end
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL four_timeout: dumpDone not seen, got %0d bytes, exp 16", hs);
      end
      checks++;
      if (rise != 3) begin
         errors++;
         $display("FAIL four_latency: byteValid rose at cycle %0d, exp 3", rise);
      end
      checks++;
      if (we_bad != 0) begin
         errors++;
         $display("FAIL busy_we: weOut nonzero in %0d busy cycles, exp 0", we_bad);
      end
      dumpEn = 1'b0;
      @(negedge clkMem);
      checks++;
      if ({busy, dumpDone} !== 2'b00) begin
         errors++;
         $display("FAIL four_release: got busy/done=%b/%b, exp 0/0", busy, dumpDone);
      end
   endtask

   task automatic test_backpressure();
      int hs = 0, cyc = 0, stall_bad = 0, seq_bad = 0;
      bit done = 0, prev_stall = 0, rdy;
      logic [8:0] prev = '0;
      wordCnt = 11'd2; byteReady = 1'b0; weIn = 4'h0; enIn = 1'b0;
      dumpEn = 1'b1;
      while (!done && cyc < 200) begin
         @(negedge clkMem); cyc++;
         if (prev_stall && {byteValid, byteData} !== prev) stall_bad++;
         rdy = (cyc % 4 == 0);
         byteReady = rdy;
         if (byteValid && rdy) begin
            if (byteData !== 8'(hs)) seq_bad++;
            hs++;
         end
         prev_stall = byteValid && !rdy;
         prev = {byteValid, byteData};
         if (dumpDone) done = 1;
      end
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL bp_stable: %0d stalled cycles changed output, exp 0", stall_bad);
      end
      checks++;
      if (seq_bad != 0) begin
         errors++;
         $display("FAIL bp_order: %0d bytes out of sequence, exp 0", seq_bad);
      end
      checks++;
      if (!done || hs != 8) begin
         errors++;
         $display("FAIL bp_count: done=%b bytes=%0d, exp done=1 bytes=8", done, hs);
      end
      dumpEn = 1'b0; byteReady = 1'b0;
      @(negedge clkMem);
   endtask

   task automatic test_zero_count();
      int bad = 0;
      wordCnt = 11'd0; enIn = 1'b1; addrIn = 10'h3FF; byteReady = 1'b1;
      dumpEn = 1'b1;
      @(negedge clkMem);
      checks++;
      if ({dumpDone, busy, byteValid, enOut} !== 4'b1100) begin
         errors++;
         $display("FAIL zero_done: got done/busy/valid/en=%b/%b/%b/%b, exp 1/1/0/0",
                  dumpDone, busy, byteValid, enOut);
      end
      repeat (4) begin
         @(negedge clkMem);
         if ({dumpDone, byteValid, enOut} !== 3'b100) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL zero_hold: %0d cycles left DONE or strobed, exp 0", bad);
      end
      dumpEn = 1'b0;
      @(negedge clkMem);
      checks++;
      if ({busy, dumpDone, enOut} !== 3'b001) begin
         errors++;
         $display("FAIL zero_release: got busy/done/en=%b/%b/%b, exp 0/0/1", busy, dumpDone, enOut);
      end
   endtask

   task automatic test_abort();
      int hs = 0, cyc = 0;
      wordCnt = 11'd8; byteReady = 1'b1; enIn = 1'b0; weIn = 4'h0; addrIn = 10'h000;
      dumpEn = 1'b1;
      while (hs < 5 && cyc < 100) begin
         @(negedge clkMem); cyc++;
         if (byteValid) hs++;
      end
      @(negedge clkMem);   // fifth byte accepted on the edge just passed
      checks++;
      if ({byteValid, byteData} !== {1'b1, 8'h05}) begin
         errors++;
         $display("FAIL abort_pre: got valid/data=%b/%h, exp 1/05", byteValid, byteData);
      end
      dumpEn = 1'b0; addrIn = 10'h123; weIn = 4'h5; enIn = 1'b1;
      @(negedge clkMem);
      checks++;
      if ({busy, dumpDone, byteValid, byteData} !== 11'h0) begin
         errors++;
         $display("FAIL abort_state: got busy/done/valid/data=%b/%b/%b/%h, exp 0/0/0/00",
                  busy, dumpDone, byteValid, byteData);
      end
      checks++;
      if ({addrOut, weOut, enOut} !== {10'h123, 4'h5, 1'b1}) begin
         errors++;
         $display("FAIL abort_port: got %h/%h/%b, exp 123/5/1", addrOut, weOut, enOut);
      end
      addrIn = 10'h3FF; weIn = 4'h0; enIn = 1'b0;
      dumpEn = 1'b1;
      @(negedge clkMem);
      checks++;
      if ({addrOut, enOut} !== {10'h000, 1'b1}) begin
         errors++;
         $display("FAIL abort_restart_rd: got addr/en=%h/%b, exp 000/1", addrOut, enOut);
      end
      repeat (2) @(negedge clkMem);
      checks++;
      if ({byteValid, byteData} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL abort_restart_byte: got valid/data=%b/%h, exp 1/00", byteValid, byteData);
      end
      dumpEn = 1'b0;
      @(negedge clkMem);
   endtask

   task automatic test_reset_mid_tx();
      wordCnt = 11'd2; byteReady = 1'b0; enIn = 1'b0;
      dumpEn = 1'b1;
      repeat (4) @(negedge clkMem);
      checks++;
      if ({byteValid, byteData} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL rst_pre: got valid/data=%b/%h, exp 1/00", byteValid, byteData);
      end
      // Handshake offered on the reset edge must lose to reset.
      byteReady = 1'b1; rstn = 1'b0;
      addrIn = 10'h0AA; weIn = 4'h6; enIn = 1'b1;
      @(negedge clkMem);
      checks++;
      if ({busy, dumpDone, byteValid, byteData} !== 11'h0) begin
         errors++;
         $display("FAIL rst_mid_state: got busy/done/valid/data=%b/%b/%b/%h, exp 0/0/0/00",
                  busy, dumpDone, byteValid, byteData);
      end
      checks++;
      if ({addrOut, weOut, enOut} !== {10'h0AA, 4'h6, 1'b1}) begin
         errors++;
         $display("FAIL rst_mid_port: got %h/%h/%b, exp 0aa/6/1", addrOut, weOut, enOut);
      end
      rstn = 1'b1; dumpEn = 1'b0; byteReady = 1'b0; enIn = 1'b0; weIn = 4'h0;
      @(negedge clkMem);
   endtask

   task automatic test_clamp();
      int hs = 0, cyc = 0, done_cyc = -1;
      logic [7:0] last_first = 8'h00;
      wordCnt = 11'h7FF; byteReady = 1'b1;
      dumpEn = 1'b1;
      while (done_cyc < 0 && cyc < 7000) begin
         @(negedge clkMem); cyc++;
         if (byteValid) begin
            if (hs == 4092) last_first = byteData;
            hs++;
         end
         if (dumpDone) done_cyc = cyc;
      end
      checks++;
      if (hs != 4096 || done_cyc != 6145) begin
         errors++;
         $display("FAIL clamp_count: got %0d bytes done at %0d, exp 4096 at 6145", hs, done_cyc);
      end
      checks++;
      if (last_first !== 8'hEF) begin
         errors++;
         $display("FAIL clamp_last_word: got %h, exp ef", last_first);
      end
      dumpEn = 1'b0;
      @(negedge clkMem);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
      ram[0] = 32'h03020100; ram[1] = 32'h07060504;
      ram[2] = 32'h0B0A0908; ram[3] = 32'h0F0E0D0C;
      ram[4] = 32'h13121110; ram[5] = 32'h17161514;
      ram[6] = 32'h1B1A1918; ram[7] = 32'h1F1E1D1C;
      ram[1023] = 32'hDEADBEEF;
      test_reset();
      test_passthrough();
      test_four_words();
      test_backpressure();
      test_zero_count();
      test_abort();
      test_reset_mid_tx();
      test_clamp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
